// File: rtl/entropy_pkg.sv
// Shared types and defaults for the entropy collector slice.
// Optional feature macro: ENTROPY_RCT_EN (Repetition Count Test).
package entropy_pkg;

  localparam int unsigned ENTROPY_DATA_WIDTH = 256;
  localparam int unsigned ENTROPY_RCT_CUTOFF = 32;
  localparam int unsigned BLOCK_COUNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_FAIL    = 3'd4
  } entropy_collector_state_t;

  function automatic logic is_busy(input entropy_collector_state_t s);
    return (s != ST_IDLE) && (s != ST_FAIL);
  endfunction

endpackage

// File: rtl/entropy_rct.sv
// Repetition Count Test: run-length counter on the raw stream with a sticky
// failure flag. Built only when ENTROPY_RCT_EN is defined.
module entropy_rct
  import entropy_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = ENTROPY_RCT_CUTOFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_valid,
  input  logic sample_bit,
  output logic trip,
  output logic fail
);

  logic [7:0] run_len;
  logic [7:0] run_next;
  logic       last_bit;
  logic       first;

  // The first sample after a clear always starts a fresh run of length 1.
  always_comb begin
    run_next = 8'd1;
    if (!first && (sample_bit == last_bit)) begin
      run_next = (run_len == 8'hFF) ? 8'hFF : run_len + 8'd1;
    end
    trip = sample_valid && (run_next >= 8'(RCT_CUTOFF));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_len  <= '0;
      last_bit <= 1'b0;
      first    <= 1'b1;
      fail     <= 1'b0;
    end else begin
      if (clear) begin
        first <= 1'b1;
      end else if (sample_valid) begin
        run_len  <= run_next;
        last_bit <= sample_bit;
        first    <= 1'b0;
      end
      if (trip) begin
        fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// Collects raw TRNG bits into DATA_WIDTH-bit blocks and hands them to the
// conditioner via start/done. ENTROPY_RCT_EN adds the Repetition Count Test.
module entropy_collector
  import entropy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ENTROPY_DATA_WIDTH,
  parameter int unsigned RCT_CUTOFF = ENTROPY_RCT_CUTOFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     raw_bit_i,
  input  logic                     raw_valid_i,
  output logic                     cond_start_o,
  output logic [DATA_WIDTH-1:0]    cond_msg_o,
  input  logic                     cond_done_i,
  output logic                     busy_o,
  output logic                     health_fail_o,
  output logic [BLOCK_COUNT_W-1:0] block_count_o
);

  localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  if ((RCT_CUTOFF < 2) || (RCT_CUTOFF > 255)) begin : g_cutoff_range
    $error("entropy_collector: RCT_CUTOFF must be within 2..255");
  end

  entropy_collector_state_t state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic [DATA_WIDTH-1:0]    msg_d;
  logic [BLOCK_COUNT_W-1:0] count_d;
  logic                     rct_trip;

`ifdef ENTROPY_RCT_EN
  logic sample_live;

  // Discarded samples (enable dropping in COLLECT) do not feed the test.
  assign sample_live = raw_valid_i &&
                       (((state_q == ST_COLLECT) && enable_i) ||
                        (state_q == ST_ISSUE) || (state_q == ST_WAIT));

  entropy_rct #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (state_q == ST_IDLE),
    .sample_valid(sample_live),
    .sample_bit  (raw_bit_i),
    .trip        (rct_trip),
    .fail        (health_fail_o)
  );
`else
  assign rct_trip      = 1'b0;
  assign health_fail_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    msg_d   = cond_msg_o;
    count_d = block_count_o;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable_i) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!enable_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (rct_trip) begin
          state_d = ST_FAIL;
        end else if (raw_valid_i) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], raw_bit_i};
          if (cnt_q == LAST_IDX) begin
            msg_d   = shift_d;
            cnt_d   = '0;
            state_d = ST_ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = rct_trip ? ST_FAIL : ST_WAIT;
      end
      ST_WAIT: begin
        if (rct_trip) begin
          state_d = ST_FAIL;
        end else if (cond_done_i) begin
          count_d = block_count_o + 1'b1;
          state_d = enable_i ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_FAIL: begin
        cnt_d   = '0;
        state_d = ST_FAIL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Start pulse and busy are registered from the next state so they line up
  // with the cycle the FSM actually occupies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      cond_msg_o    <= '0;
      cond_start_o  <= 1'b0;
      busy_o        <= 1'b0;
      block_count_o <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      cond_msg_o    <= msg_d;
      cond_start_o  <= (state_d == ST_ISSUE);
      busy_o        <= is_busy(state_d);
      block_count_o <= count_d;
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Self-checking bench for entropy_collector: randomized blocks compared with
// a bit-list reference, plus a latency-programmable conditioner model.
module tb_entropy_collector;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i;
  logic          raw_bit_i;
  logic          raw_valid_i;
  logic          cond_start_o;
  logic [DW-1:0] cond_msg_o;
  logic          cond_done_i;
  logic          busy_o;
  logic          health_fail_o;
  logic [15:0]   block_count_o;

  int tests = 0;
  int fails = 0;

  int            start_seen;
  int            done_timer;
  int            cond_latency = 20;
  int            exp_count = 0;
  logic [DW-1:0] exp_msg;
  bit            blk[$];

  always #5 clk = ~clk;

  entropy_collector #(
    .DATA_WIDTH(DW),
    .RCT_CUTOFF(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .raw_bit_i    (raw_bit_i),
    .raw_valid_i  (raw_valid_i),
    .cond_start_o (cond_start_o),
    .cond_msg_o   (cond_msg_o),
    .cond_done_i  (cond_done_i),
    .busy_o       (busy_o),
    .health_fail_o(health_fail_o),
    .block_count_o(block_count_o)
  );

  // Conditioner model: answers done cond_latency cycles after each start.
  initial begin
    cond_done_i = 1'b0;
    done_timer  = 0;
    start_seen  = 0;
    forever begin
      @(posedge clk);
      #2;
      cond_done_i = 1'b0;
      if (!rst_n) begin
        done_timer = 0;
      end else begin
        if (done_timer > 0) begin
          done_timer--;
          if (done_timer == 0) cond_done_i = 1'b1;
        end
        if (cond_start_o === 1'b1) begin
          start_seen++;
          done_timer = cond_latency;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_alt(input int n);
    for (int i = 0; i < n; i++) blk.push_back(bit'(i % 2 == 0));
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) blk.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic fill_ff00(input int n);
    for (int i = 0; i < n; i++) blk.push_back(bit'((i / 8) % 2 == 0));
  endtask

  task automatic fill_const(input int n, input bit v);
    for (int i = 0; i < n; i++) blk.push_back(v);
  endtask

  // Drives blk as DW valid samples (first sample lands at the message MSB)
  // and leaves the bench in the cycle after the last sample's edge.
  task automatic drive_block(input bit gaps);
    exp_msg = '0;
    for (int i = 0; i < DW; i++) begin
      exp_msg[DW-1-i] = blk[i];
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          raw_valid_i = 1'b0;
          raw_bit_i   = 1'($urandom);
          tick();
        end
      end
      raw_valid_i = 1'b1;
      raw_bit_i   = blk[i];
      tick();
    end
    raw_valid_i = 1'b0;
    blk.delete();
  endtask

  // Waits for block_count_o to move; optionally feeds junk samples meanwhile.
  task automatic wait_done(input bit junk, output bit ok);
    int c0;
    c0 = int'(block_count_o);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      raw_valid_i = junk;
      raw_bit_i   = 1'($urandom);
      tick();
      if (int'(block_count_o) != c0) begin
        ok = 1'b1;
        break;
      end
    end
    raw_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable_i    = 1'b0;
    raw_valid_i = 1'b0;
    raw_bit_i   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (cond_start_o !== 1'b0) begin fails++; $display("FAIL reset_start got=%b exp=0", cond_start_o); end
    tests++; if (cond_msg_o !== '0) begin fails++; $display("FAIL reset_msg got=%h exp=0", cond_msg_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    tests++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL reset_health got=%b exp=0", health_fail_o); end
    tests++; if (block_count_o !== 16'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", block_count_o); end
  endtask

  task automatic test_alternating();
    int s0;
    bit ok;
    s0 = start_seen;
    enable_i    = 1'b1;
    raw_valid_i = 1'b1;
    raw_bit_i   = 1'($urandom);
    tick();
    fill_alt(DW);
    drive_block(1'b0);
    tests++; if (cond_start_o !== 1'b1) begin fails++; $display("FAIL alt_start got=%b exp=1", cond_start_o); end
    tests++; if (cond_msg_o !== exp_msg) begin fails++; $display("FAIL alt_msg got=%h exp=%h", cond_msg_o, exp_msg); end
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL alt_busy_issue got=%b exp=1", busy_o); end
    tick();
    tests++; if (cond_start_o !== 1'b0) begin fails++; $display("FAIL alt_start_pulse got=%b exp=0", cond_start_o); end
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL alt_busy_wait got=%b exp=1", busy_o); end
    wait_done(1'b0, ok);
    exp_count++;
    tests++; if (!ok) begin fails++; $display("FAIL alt_done_timeout got=none exp=done"); end
    tests++; if (block_count_o !== 16'(exp_count)) begin fails++; $display("FAIL alt_count got=%0d exp=%0d", block_count_o, exp_count); end
    tests++; if (start_seen - s0 !== 1) begin fails++; $display("FAIL alt_start_count got=%0d exp=1", start_seen - s0); end
    tests++; if (cond_msg_o !== exp_msg) begin fails++; $display("FAIL alt_msg_hold got=%h exp=%h", cond_msg_o, exp_msg); end
  endtask

  task automatic test_wait_drop();
    bit ok;
    fill_rand(DW);
    drive_block(1'b0);
    tests++; if (cond_msg_o !== exp_msg) begin fails++; $display("FAIL drop_msg1 got=%h exp=%h", cond_msg_o, exp_msg); end
    wait_done(1'b1, ok);
    exp_count++;
    tests++; if (!ok || block_count_o !== 16'(exp_count)) begin fails++; $display("FAIL drop_count1 got=%0d exp=%0d", block_count_o, exp_count); end
    fill_ff00(DW);
    drive_block(1'b0);
    tests++; if (cond_start_o !== 1'b1) begin fails++; $display("FAIL drop_start2 got=%b exp=1", cond_start_o); end
    tests++; if (cond_msg_o !== exp_msg) begin fails++; $display("FAIL drop_msg2 got=%h exp=%h", cond_msg_o, exp_msg); end
    wait_done(1'b0, ok);
    exp_count++;
    tests++; if (!ok || block_count_o !== 16'(exp_count)) begin fails++; $display("FAIL drop_count2 got=%0d exp=%0d", block_count_o, exp_count); end
  endtask

  task automatic test_abort();
    int s0;
    bit ok;
    s0 = start_seen;
    for (int i = 0; i < 100; i++) begin
      raw_valid_i = 1'b1;
      raw_bit_i   = 1'($urandom);
      tick();
    end
    enable_i  = 1'b0;
    raw_bit_i = 1'($urandom);
    tick();
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    repeat (10) begin
      raw_bit_i = 1'($urandom);
      tick();
    end
    tests++; if (start_seen != s0) begin fails++; $display("FAIL abort_no_start got=%0d exp=%0d", start_seen, s0); end
    enable_i = 1'b1;
    tick();
    fill_rand(DW);
    drive_block(1'b0);
    tests++; if (cond_start_o !== 1'b1) begin fails++; $display("FAIL abort_start got=%b exp=1", cond_start_o); end
    tests++; if (cond_msg_o !== exp_msg) begin fails++; $display("FAIL abort_msg got=%h exp=%h", cond_msg_o, exp_msg); end
    enable_i = 1'b0;
    wait_done(1'b0, ok);
    exp_count++;
    tests++; if (!ok || block_count_o !== 16'(exp_count)) begin fails++; $display("FAIL abort_count got=%0d exp=%0d", block_count_o, exp_count); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_idle_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_random_blocks();
    bit ok;
    enable_i = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      cond_latency = $urandom_range(1, 30);
      fill_rand(DW);
      drive_block(1'b1);
      tests++; if (cond_start_o !== 1'b1 || cond_msg_o !== exp_msg) begin fails++; $display("FAIL rand_msg%0d got=%h exp=%h", b, cond_msg_o, exp_msg); end
      wait_done(1'b1, ok);
      exp_count++;
      tests++; if (!ok || block_count_o !== 16'(exp_count)) begin fails++; $display("FAIL rand_count%0d got=%0d exp=%0d", b, block_count_o, exp_count); end
    end
    cond_latency = 20;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    fill_rand(DW);
    drive_block(1'b0);
    tick();
    rst_n    = 1'b0;
    enable_i = 1'b0;
    tick();
    tests++; if (cond_msg_o !== '0 || cond_start_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL rstw_outputs got=%b/%b/%h exp=0/0/0", cond_start_o, busy_o, cond_msg_o); end
    tests++; if (block_count_o !== 16'd0 || health_fail_o !== 1'b0) begin fails++; $display("FAIL rstw_count got=%0d/%b exp=0/0", block_count_o, health_fail_o); end
    exp_count = 0;
    rst_n = 1'b1;
    tick();
    enable_i = 1'b1;
    tick();
    fill_rand(DW);
    drive_block(1'b0);
    tests++; if (cond_start_o !== 1'b1 || cond_msg_o !== exp_msg) begin fails++; $display("FAIL rstw_msg got=%h exp=%h", cond_msg_o, exp_msg); end
    wait_done(1'b0, ok);
    exp_count++;
    tests++; if (!ok || block_count_o !== 16'd1) begin fails++; $display("FAIL rstw_count_after got=%0d exp=1", block_count_o); end
  endtask

`ifdef ENTROPY_RCT_EN
  task automatic test_rct_cutoff();
    int s0;
    do_reset();
    enable_i = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      raw_valid_i = 1'b1;
      raw_bit_i   = (i < 31);
      tick();
    end
    tests++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL rct_31_ones got=%b exp=0", health_fail_o); end
    for (int i = 0; i < 32; i++) begin
      raw_valid_i = 1'b1;
      raw_bit_i   = 1'b1;
      tick();
      if (i == 30) begin
        tests++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL rct_early got=%b exp=0", health_fail_o); end
      end
    end
    tests++; if (health_fail_o !== 1'b1) begin fails++; $display("FAIL rct_trip got=%b exp=1", health_fail_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rct_fail_busy got=%b exp=0", busy_o); end
    s0 = start_seen;
    for (int i = 0; i < 300; i++) begin
      raw_bit_i = 1'($urandom);
      tick();
    end
    raw_valid_i = 1'b0;
    tests++; if (start_seen != s0 || health_fail_o !== 1'b1) begin fails++; $display("FAIL rct_terminal got=%0d/%b exp=%0d/1", start_seen, health_fail_o, s0); end
  endtask

  task automatic test_rct_boundary();
    int s0;
    do_reset();
    enable_i = 1'b1;
    tick();
    s0 = start_seen;
    fill_alt(DW - 32);
    fill_const(32, 1'b1);
    drive_block(1'b0);
    tests++; if (health_fail_o !== 1'b1) begin fails++; $display("FAIL rctb_health got=%b exp=1", health_fail_o); end
    tests++; if (cond_start_o !== 1'b0) begin fails++; $display("FAIL rctb_start got=%b exp=0", cond_start_o); end
    repeat (30) tick();
    tests++; if (start_seen != s0 || block_count_o !== 16'd0) begin fails++; $display("FAIL rctb_no_issue got=%0d/%0d exp=%0d/0", start_seen, block_count_o, s0); end
  endtask
`else
  task automatic test_no_rct();
    bit ok;
    fill_const(DW, 1'b1);
    drive_block(1'b0);
    tests++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL norct_health got=%b exp=0", health_fail_o); end
    tests++; if (cond_start_o !== 1'b1 || cond_msg_o !== exp_msg) begin fails++; $display("FAIL norct_msg got=%h exp=%h", cond_msg_o, exp_msg); end
    wait_done(1'b0, ok);
    exp_count++;
    tests++; if (!ok || block_count_o !== 16'(exp_count)) begin fails++; $display("FAIL norct_count got=%0d exp=%0d", block_count_o, exp_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_alternating();
    test_wait_drop();
    test_abort();
    test_random_blocks();
    test_reset_in_wait();
`ifdef ENTROPY_RCT_EN
    test_rct_cutoff();
    test_rct_boundary();
`else
    test_no_rct();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
